// File: rtl/sdhci_rsp_pkg.sv
// Shared types and constants for the SD CMD-line response path.
package sdhci_rsp_pkg;

    typedef enum logic [1:0] {
        R48_CRC   = 2'd0,
        R48_NOCRC = 2'd1,
        R136      = 2'd2,
        RSP_RSVD  = 2'd3
    } rsp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECEIVE    = 2'd2,
        ST_DONE       = 2'd3
    } rsp_state_e;

    localparam int RspShortLen = 48;
    localparam int RspLongLen  = 136;

    // CRC7 coverage windows in transmission-order bit index k
    localparam int ShortCrcLo = 0;
    localparam int ShortCrcHi = 39;
    localparam int LongCrcLo  = 8;
    localparam int LongCrcHi  = 127;

    localparam int ShiftW = 127;

    // Reserved encoding behaves like a short response without CRC
    function automatic rsp_type_e norm_type(input rsp_type_e t);
        return (t == RSP_RSVD) ? R48_NOCRC : t;
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), zero seed, MSB-first message order.
// Shared between the command transmitter and the response receiver.
module crc7_serial (
    input  logic       sd_clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       dat_i,
    output logic [6:0] crc_o
);

    logic fb;

    assign fb = dat_i ^ crc_o[6];

    // Shift one message bit into the CRC register when enabled
    always_ff @(posedge sd_clk_i) begin
        if (rst_i || clear_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

endmodule

// File: rtl/rsp_receiver.sv
// CMD-line response receiver: captures R48/R136 responses, checks CRC7,
// end bit and command index.
// Optional response timeout is built when SDHCI_RSP_TIMEOUT_EN is defined;
// otherwise WAIT_START waits until abort or reset.
//
// state      | meaning
// IDLE       | ready for a new listen request
// WAIT_START | sampling CMD for the start bit (N_CR window)
// RECEIVE    | shifting in bits k=1..L-1
// DONE       | one-cycle result strobe
module rsp_receiver
    import sdhci_rsp_pkg::*;
#(
    parameter int TimeoutCycles = 64
) (
    input  logic         sd_clk_i,
    input  logic         rst_i,
    input  logic         cmd_i,
    input  logic         start_i,
    input  logic [1:0]   rsp_type_i,
    input  logic [5:0]   cmd_index_i,
    input  logic         abort_i,
    output logic         ready_o,
    output logic         receiving_o,
    output logic         rsp_valid_o,
    output logic [119:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o,
    output logic         timeout_err_o
);

    rsp_state_e         state_q, state_d;
    rsp_type_e          type_q;
    logic [5:0]         idx_q;
    logic [7:0]         bit_cnt_q;
    logic [6:0]         hdr_q;
    logic [ShiftW-1:0]  sreg_q;
    logic [6:0]         crc_val;

    logic       is_long;
    logic [7:0] last_k;
    logic [7:0] crc_lo;
    logic [7:0] crc_hi;
    logic       accept;
    logic       start_seen;
    logic       end_seen;
    logic       shifting;
    logic       crc_en;
    logic       timeout_hit;

    assign is_long    = (type_q == R136);
    assign last_k     = is_long ? 8'(RspLongLen - 1) : 8'(RspShortLen - 1);
    assign crc_lo     = is_long ? 8'(LongCrcLo) : 8'(ShortCrcLo);
    assign crc_hi     = is_long ? 8'(LongCrcHi) : 8'(ShortCrcHi);

    assign accept     = (state_q == ST_IDLE) && start_i && !abort_i;
    assign start_seen = (state_q == ST_WAIT_START) && !cmd_i && !abort_i;
    assign end_seen   = (state_q == ST_RECEIVE) && (bit_cnt_q == last_k) && !abort_i;
    assign shifting   = (state_q == ST_RECEIVE) && (bit_cnt_q != last_k) && !abort_i;

    // Start bit (k=0) only counts toward the CRC when the window begins at 0
    assign crc_en = (start_seen && (crc_lo == 8'd0)) ||
                    (shifting && (bit_cnt_q >= crc_lo) && (bit_cnt_q <= crc_hi));

`ifdef SDHCI_RSP_TIMEOUT_EN
    localparam int ToW = $clog2(TimeoutCycles + 1);

    logic [ToW-1:0] to_cnt_q;
    logic           timeout_err_q;

    // A start bit on the final sample wins, so timeout needs cmd_i high
    assign timeout_hit = (state_q == ST_WAIT_START) && cmd_i && !abort_i &&
                         (to_cnt_q == ToW'(TimeoutCycles - 1));

    // Count idle CMD samples while waiting; saturate instead of wrapping
    always_ff @(posedge sd_clk_i) begin
        if (rst_i || accept) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_WAIT_START) && cmd_i &&
                     (to_cnt_q != ToW'(TimeoutCycles))) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Timeout flag follows the most recent result
    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end else if (end_seen) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    crc7_serial u_crc (
        .sd_clk_i (sd_clk_i),
        .rst_i    (rst_i),
        .clear_i  (accept),
        .en_i     (crc_en),
        .dat_i    (cmd_i),
        .crc_o    (crc_val)
    );

    // State register
    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode; abort overrides every transition
    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        receiving_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!cmd_i) state_d = ST_RECEIVE;
                else if (timeout_hit) state_d = ST_DONE;
            end
            ST_RECEIVE: begin
                receiving_o = 1'b1;
                if (bit_cnt_q == last_k) state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // Request latch, bit counter and capture registers
    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            type_q    <= R48_CRC;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            sreg_q    <= '0;
        end else if (accept) begin
            type_q    <= norm_type(rsp_type_e'(rsp_type_i));
            idx_q     <= cmd_index_i;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            sreg_q    <= '0;
        end else if (start_seen) begin
            bit_cnt_q <= 8'd1;
        end else if (shifting) begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
            sreg_q    <= {sreg_q[ShiftW-2:0], cmd_i};
            // k=1..7 (transmission bit + index) kept separately since the
            // long frame pushes them out of the shift register
            if (bit_cnt_q <= 8'd7) hdr_q <= {hdr_q[5:0], cmd_i};
        end
    end

    // Result registers, loaded on the end-bit sample or on timeout
    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            rsp_o         <= '0;
            rsp_index_o   <= '0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            index_err_o   <= 1'b0;
        end else if (timeout_hit) begin
            rsp_o         <= '0;
            rsp_index_o   <= '0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            index_err_o   <= 1'b0;
        end else if (end_seen) begin
            rsp_o         <= is_long ? sreg_q[126:7] : {88'b0, sreg_q[38:7]};
            rsp_index_o   <= hdr_q[5:0];
            crc_err_o     <= (type_q != R48_NOCRC) && (crc_val != sreg_q[6:0]);
            end_bit_err_o <= !cmd_i;
            index_err_o   <= (type_q == R48_CRC) &&
                             ((hdr_q[5:0] != idx_q) || hdr_q[6]);
        end
    end

endmodule

// File: tb/tb_rsp_receiver.sv
// Testbench for rsp_receiver. Frames are built from field values and
// expectations derived from the response format rules.
module tb_rsp_receiver;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         cmd_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   rsp_type_i = '0;
    logic [5:0]   cmd_index_i = '0;
    logic         abort_i = 1'b0;
    logic         ready_o, receiving_o, rsp_valid_o;
    logic [119:0] rsp_o;
    logic [5:0]   rsp_index_o;
    logic         crc_err_o, end_bit_err_o, index_err_o, timeout_err_o;

    int errors = 0;
    int checks = 0;
    logic [119:0] last_rsp = '0;
    logic [5:0]   last_idx = '0;

    always #5 clk = ~clk;

    rsp_receiver #(.TimeoutCycles(64)) dut (
        .sd_clk_i      (clk),
        .rst_i         (rst_i),
        .cmd_i         (cmd_i),
        .start_i       (start_i),
        .rsp_type_i    (rsp_type_i),
        .cmd_index_i   (cmd_index_i),
        .abort_i       (abort_i),
        .ready_o       (ready_o),
        .receiving_o   (receiving_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_o         (rsp_o),
        .rsp_index_o   (rsp_index_o),
        .crc_err_o     (crc_err_o),
        .end_bit_err_o (end_bit_err_o),
        .index_err_o   (index_err_o),
        .timeout_err_o (timeout_err_o)
    );

    function automatic logic [6:0] crc7_of(input logic [135:0] fr, input int lo, input int hi);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int k = lo; k <= hi; k++) begin
            fb = fr[k] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Send one response frame and check the result.
    // crc_raw=1: crc_val is the literal CRC field; else it is XORed onto the correct CRC.
    // cut_k>=0: abort (or reset when cut_rst) together with bit k.
    task automatic run_frame(input logic [1:0] typ, input logic [5:0] cidx,
                             input logic [5:0] hidx, input logic tbit,
                             input logic [119:0] payload, input bit crc_raw,
                             input logic [6:0] crc_val, input logic end_bit,
                             input int gap, input int cut_k, input bit cut_rst,
                             input bit noise, input string name);
        logic [135:0] fr;
        logic [6:0]   crc_good, crc_f;
        logic [119:0] e_rsp;
        logic         e_crc, e_idx, e_end;
        bit           long_f, early;
        int           len, lo, hi, lat;
        long_f = (typ == 2'd2);
        len = long_f ? 136 : 48;
        lo  = long_f ? 8 : 0;
        hi  = len - 9;
        fr = '0;
        fr[1] = tbit;
        for (int i = 0; i < 6; i++) fr[2 + i] = hidx[5 - i];
        if (long_f) for (int i = 0; i < 120; i++) fr[8 + i] = payload[119 - i];
        else        for (int i = 0; i < 32; i++)  fr[8 + i] = payload[31 - i];
        crc_good = crc7_of(fr, lo, hi);
        crc_f = crc_raw ? crc_val : (crc_good ^ crc_val);
        for (int i = 0; i < 7; i++) fr[hi + 1 + i] = crc_f[6 - i];
        fr[len - 1] = end_bit;
        e_rsp = long_f ? payload : {88'b0, payload[31:0]};
        e_crc = ((typ == 2'd0) || (typ == 2'd2)) && (crc_f != crc_good);
        e_idx = (typ == 2'd0) && ((hidx != cidx) || tbit);
        e_end = !end_bit;
        early = 0;

        start_i = 1'b1; rsp_type_i = typ; cmd_index_i = cidx; cmd_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL %s accept ready_o got=%b exp=0", name, ready_o); end
        checks++;
        if (rsp_o !== last_rsp) begin errors++; $display("FAIL %s held rsp_o got=%h exp=%h", name, rsp_o, last_rsp); end
        for (int g = 0; g < gap; g++) begin
            cmd_i = 1'b1;
            @(negedge clk);
            if (rsp_valid_o) early = 1;
        end
        for (int k = 0; k < len; k++) begin
            cmd_i = fr[k];
            if (k == cut_k) begin
                if (cut_rst) rst_i = 1'b1; else abort_i = 1'b1;
            end
            if (noise && k == 10) begin
                start_i = 1'b1; rsp_type_i = 2'($urandom); cmd_index_i = 6'($urandom);
            end
            @(negedge clk);
            start_i = 1'b0;
            if (k == cut_k) begin
                rst_i = 1'b0; abort_i = 1'b0; cmd_i = 1'b1;
                checks++;
                if (ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || receiving_o !== 1'b0) begin
                    errors++; $display("FAIL %s cut ready/valid/recv got=%b%b%b exp=100", name, ready_o, rsp_valid_o, receiving_o);
                end
                if (cut_rst) begin last_rsp = '0; last_idx = '0; end
                checks++;
                if (rsp_o !== last_rsp || rsp_index_o !== last_idx) begin
                    errors++; $display("FAIL %s cut rsp got=%h/%h exp=%h/%h", name, rsp_o, rsp_index_o, last_rsp, last_idx);
                end
                if (cut_rst) begin
                    checks++;
                    if ({crc_err_o, end_bit_err_o, index_err_o, timeout_err_o} !== 4'b0) begin
                        errors++; $display("FAIL %s reset flags got=%b exp=0000", name, {crc_err_o, end_bit_err_o, index_err_o, timeout_err_o});
                    end
                end
                for (int j = 0; j < len; j++) begin
                    @(negedge clk);
                    if (rsp_valid_o) early = 1;
                end
                checks++;
                if (early) begin errors++; $display("FAIL %s cut spurious rsp_valid_o got=1 exp=0", name); end
                return;
            end
            if (k == 0) begin
                checks++;
                if (receiving_o !== 1'b1) begin errors++; $display("FAIL %s receiving_o got=%b exp=1", name, receiving_o); end
            end
            if (k < len - 1 && rsp_valid_o) early = 1;
        end
        cmd_i = 1'b1;
        lat = len;
        while (!rsp_valid_o && lat < len + 4) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (early || lat != len) begin
            errors++; $display("FAIL %s latency got=%0d early=%0d exp=%0d", name, lat, early, len);
        end
        checks++;
        if (rsp_o !== e_rsp) begin errors++; $display("FAIL %s rsp_o got=%h exp=%h", name, rsp_o, e_rsp); end
        checks++;
        if (rsp_index_o !== hidx) begin errors++; $display("FAIL %s rsp_index_o got=%h exp=%h", name, rsp_index_o, hidx); end
        checks++;
        if (crc_err_o !== e_crc) begin errors++; $display("FAIL %s crc_err_o got=%b exp=%b", name, crc_err_o, e_crc); end
        checks++;
        if (end_bit_err_o !== e_end) begin errors++; $display("FAIL %s end_bit_err_o got=%b exp=%b", name, end_bit_err_o, e_end); end
        checks++;
        if (index_err_o !== e_idx) begin errors++; $display("FAIL %s index_err_o got=%b exp=%b", name, index_err_o, e_idx); end
        checks++;
        if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL %s timeout_err_o got=%b exp=0", name, timeout_err_o); end
        last_rsp = e_rsp;
        last_idx = hidx;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL %s post valid/ready got=%b%b exp=01", name, rsp_valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || receiving_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset status got=%b%b%b exp=100", ready_o, receiving_o, rsp_valid_o);
        end
        checks++;
        if (rsp_o !== '0 || rsp_index_o !== '0 ||
            {crc_err_o, end_bit_err_o, index_err_o, timeout_err_o} !== 4'b0) begin
            errors++; $display("FAIL reset results got=%h/%h/%b exp=0", rsp_o, rsp_index_o,
                               {crc_err_o, end_bit_err_o, index_err_o, timeout_err_o});
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_r48();
        run_frame(2'd0, 6'd17, 6'd17, 1'b0, 120'h900, 1'b1, 7'h33, 1'b1, 3, -1, 0, 0, "r48_good");
        run_frame(2'd0, 6'd17, 6'd17, 1'b0, 120'h901, 1'b1, 7'h33, 1'b1, 0, -1, 0, 0, "r48_crc_flip");
        run_frame(2'd0, 6'd17, 6'd17, 1'b0, 120'h900, 1'b1, 7'h33, 1'b0, 2, -1, 0, 0, "r48_end0");
        run_frame(2'd0, 6'd18, 6'd17, 1'b0, 120'h900, 1'b1, 7'h33, 1'b1, 1, -1, 0, 0, "r48_idx");
        run_frame(2'd0, 6'd17, 6'd17, 1'b1, 120'h900, 1'b1, 7'h33, 1'b1, 1, -1, 0, 0, "r48_tbit");
    endtask

    task automatic test_r136();
        run_frame(2'd2, 6'd2, 6'h3F, 1'b0, 120'h0353_4453_4430_3847_8012_3456_7800_C4,
                  1'b0, 7'h00, 1'b1, 4, -1, 0, 0, "r136_cid");
    endtask

    task automatic test_nocrc();
        run_frame(2'd1, 6'd41, 6'h3F, 1'b0, 120'h80FF_8000, 1'b1, 7'h7F, 1'b1, 2, -1, 0, 0, "r3");
        run_frame(2'd3, 6'd41, 6'h3F, 1'b0, 120'h00FF_8000, 1'b1, 7'h15, 1'b1, 0, -1, 0, 0, "rsvd_type");
    endtask

    task automatic test_abort_reset();
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_vs_start ready_o got=%b exp=1", ready_o); end
        run_frame(2'd0, 6'd7, 6'd7, 1'b0, 120'hDEAD_BEEF, 1'b0, 7'h00, 1'b1, 2, 20, 0, 0, "abort_k20");
        run_frame(2'd0, 6'd7, 6'd7, 1'b0, 120'h1234_5678, 1'b0, 7'h00, 1'b1, 2, -1, 0, 0, "after_abort");
        run_frame(2'd2, 6'd0, 6'h3F, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                  1'b0, 7'h00, 1'b1, 1, 100, 1, 0, "reset_k100");
        run_frame(2'd0, 6'd9, 6'd9, 1'b0, 120'hCAFE_F00D, 1'b0, 7'h00, 1'b1, 0, -1, 0, 0, "after_reset");
    endtask

`ifdef SDHCI_RSP_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        first = -1;
        start_i = 1'b1; rsp_type_i = 2'd0; cmd_index_i = 6'd5; cmd_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (rsp_valid_o && first < 0) begin
                first = c;
                checks++;
                if (timeout_err_o !== 1'b1 || {crc_err_o, end_bit_err_o, index_err_o} !== 3'b0) begin
                    errors++; $display("FAIL timeout flags got=%b exp=1000",
                                       {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o});
                end
                checks++;
                if (rsp_o !== '0 || rsp_index_o !== '0) begin
                    errors++; $display("FAIL timeout rsp got=%h/%h exp=0/0", rsp_o, rsp_index_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (first != 65) begin errors++; $display("FAIL timeout cycle got=%0d exp=65", first); end
        last_rsp = '0; last_idx = '0;
        run_frame(2'd0, 6'd17, 6'd17, 1'b0, 120'h900, 1'b1, 7'h33, 1'b1, 63, -1, 0, 0, "start_at_last");
    endtask
`else
    task automatic test_no_timeout();
        run_frame(2'd0, 6'd17, 6'd17, 1'b0, 120'h900, 1'b1, 7'h33, 1'b1, 150, -1, 0, 0, "long_wait");
    endtask
`endif

    task automatic test_random();
        logic [1:0]   typ;
        logic [5:0]   cidx, hidx;
        logic [119:0] pl;
        logic [6:0]   cx;
        for (int n = 0; n < 24; n++) begin
            typ  = 2'($urandom_range(0, 3));
            cidx = 6'($urandom);
            hidx = ($urandom_range(0, 3) == 0) ? 6'($urandom) : cidx;
            pl   = {$urandom, $urandom, $urandom, $urandom};
            cx   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'h00;
            run_frame(typ, cidx, hidx, ($urandom_range(0, 7) == 0), pl, 1'b0, cx,
                      ($urandom_range(0, 5) != 0), $urandom_range(0, 8), -1, 0,
                      ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_r48();
        test_r136();
        test_nocrc();
        test_abort_reset();
`ifdef SDHCI_RSP_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsp_receiver.md
# rsp_receiver

Parametrised CMD-line response receiver for the SD host controller: the next generation of the single-format response reader. It captures 48-bit and 136-bit responses in the `sd_clk_i` domain and checks CRC7, end bit and command index. It also detects a response timeout (optional, see Configuration), supports a no-CRC response format (R3/R4) and allows software abort. Results are held in registered form for the register-file synchroniser.

## Interface
- `TimeoutCycles`, default 64: number of `cmd_i` samples without a start bit before timeout (N_CR limit).
- `sd_clk_i`, input, 1: SD clock. All logic is in this domain.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `cmd_i`, input, 1: CMD line, sampled every rising edge.
- `start_i`, input, 1: request to listen. Accepted only when `start_i && ready_o`.
- `rsp_type_i`, input, 2: `rsp_type_e` value, latched on accept.
- `cmd_index_i`, input, 6: expected response index, latched on accept.
- `abort_i`, input, 1: return to IDLE immediately with no result.
- `ready_o`, output, 1: high in IDLE.
- `receiving_o`, output, 1: high in RECEIVE.
- `rsp_valid_o`, output, 1: one-cycle pulse; result and flags are valid.
- `rsp_o`, output, 120: R136 gives CID/CSD[127:8]. R48 gives the argument in [31:0], with [119:32] = 0.
- `rsp_index_o`, output, 6: received bits k=2..7.
- `crc_err_o`, `end_bit_err_o`, `index_err_o`, `timeout_err_o`: outputs, 1 bit each.

## Operation
- Bit index k is transmission order. k=0 is the start bit; k=L-1 is the end bit.
  - L = 48 for R48_CRC and R48_NOCRC.
  - L = 136 for R136.
- States: IDLE, WAIT_START, RECEIVE, DONE.
  - **IDLE.** On accept, latch type and index, clear the counters, go to WAIT_START.
  - **WAIT_START.**
    - `cmd_i`=0: go to RECEIVE. The bit counter becomes 1.
    - Otherwise, increment the timeout counter. When it reaches `TimeoutCycles`, go to DONE with timeout.
  - **RECEIVE.** Shift `cmd_i` in and increment the bit counter. Sampling k=L-1 moves to DONE.
  - **DONE.** Pulse `rsp_valid_o` for one cycle, then go to IDLE.
- CRC7 (polynomial x^7+x^3+1, zero seed) coverage:
  - R48_CRC: k=0..39, compared against k=40..46.
  - R136: k=8..127, compared against k=128..134.
  - R48_NOCRC: `crc_err_o` is forced to 0.
- `index_err_o` is set, for R48_CRC only, when `rsp_index_o != cmd_index_i` or the transmission bit (k=1) is 1.
- `end_bit_err_o` = end bit sampled as 0.
- On timeout:
  - `timeout_err_o` = 1.
  - The other three flags = 0.
  - `rsp_o` and `rsp_index_o` are cleared to 0.
- `abort_i` in any state forces IDLE next cycle, with no `rsp_valid_o`. `abort_i` beats `start_i` in the same cycle.
- `start_i` outside IDLE is ignored (no queueing).
- Result outputs are registered and hold until the next DONE or reset. A new accept does not clear them.

## Timing
- Reset: state IDLE, every output 0 except `ready_o` = 1, all counters and CRC cleared. Reset mid-receive discards the response.
- Accept at edge t: WAIT_START from t+1. The first `cmd_i` sample is at t+1.
- Start bit sampled at edge s: end bit at s+L-1, `rsp_valid_o` high in cycle s+L, `ready_o` high from s+L+1.
- Timeout: `rsp_valid_o` in cycle t+1+`TimeoutCycles`.
  - A start bit on the final sample (t+`TimeoutCycles`) wins over timeout.
- Timeout counter width is `$clog2(TimeoutCycles+1)` and does not wrap.
- Bit counter is 8 bits (max 135) and does not wrap.
- Back-to-back: a new accept is possible in the cycle after DONE.

## Configuration
- `SDHCI_RSP_TIMEOUT_EN` defined:
  - The timeout counter and timeout path exist.
- Undefined:
  - WAIT_START waits indefinitely; only `abort_i` or reset exits.
  - `timeout_err_o` is tied to 0.
  - `TimeoutCycles` is unused.
  - No counter flops are generated.

## Structure
- `sdhci_rsp_pkg` holds:
  - `rsp_type_e` (R48_CRC=0, R48_NOCRC=1, R136=2; 3 is reserved and treated as R48_NOCRC).
  - `RspShortLen`=48 and `RspLongLen`=136.
  - The CRC window bounds.
- Sub-module `crc7_serial` (ports: `sd_clk_i`, `rst_i`, `clear_i`, `en_i`, `dat_i`, `crc_o[6:0]`) is shared with the command transmitter.
- Shift register: 127 bits in-module, capturing k=1..L-2 and right-aligned at the end.

## Test plan
- **R48_CRC, good response.**
  - Stimulus: `cmd_index_i`=17; response 0x11, argument 0x0000_0900, CRC7 0x33, end bit 1.
  - Required: `rsp_valid_o` 48 cycles after the start bit; `rsp_o`=0x900; `rsp_index_o`=17; all flags 0.
- **Corrupted and mismatched fields.**
  - Same frame with argument bit 0 flipped: `crc_err_o`=1 only.
  - End bit 0: `end_bit_err_o`=1.
  - `cmd_index_i`=18: `index_err_o`=1.
- **R136.**
  - Stimulus: header 0x3F, CID[127:8]=0x0353_4453_4430_3847_8012_3456_7800_C4, correct CRC.
  - Required: `rsp_o` equals that value; valid 136 cycles after the start bit; flags 0.
- **R48_NOCRC (R3).**
  - Stimulus: OCR 0x80FF_8000, CRC field 0x7F, index 0x3F.
  - Required: no `crc_err_o`, no `index_err_o`.
- **Timeout (macro defined, `TimeoutCycles`=64).**
  - `cmd_i` held at 1: `timeout_err_o` pulse in cycle t+65.
  - Start bit at t+64: normal reception, no timeout.
- **Abort and reset.**
  - `abort_i` at k=20: no `rsp_valid_o`; `ready_o` next cycle.
  - `rst_i` at k=100 of R136: all outputs 0.
  - A subsequent R48 is received correctly in both cases.
